// File: rtl/cpu_mem_responder.sv
// Harvard memory responder for the 32-bit CPU: combinational instruction and
// data read ports, clocked data stores with a saturating store counter, and a
// byte-serial program loader that fills instruction memory while holding the
// CPU in reset. Bit 0 of a word is its MSB.
module cpu_mem_responder #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDRSIZE = 12,
  parameter int unsigned CNTW     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDRSIZE-1:0] MEM_ADDR,
  input  logic [0:WIDTH-1]    MEM_WDATA,
  input  logic                MEM_CTRL,
  output logic [0:WIDTH-1]    MEM_RDATA,
  input  logic [ADDRSIZE-1:0] INS_ADDR,
  output logic [0:WIDTH-1]    INS_MEM,
  input  logic                LD_START,
  input  logic                LD_VALID,
  input  logic [7:0]          LD_BYTE,
  input  logic                LD_LAST,
  output logic                LD_READY,
  output logic                CPU_HOLD,
  output logic [ADDRSIZE:0]   LD_COUNT,
  output logic                LD_ERR,
  output logic [CNTW-1:0]     WR_COUNT
);

  localparam int unsigned DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE-1:0] ADDR_ONE = 1;
  localparam logic [ADDRSIZE:0]   CNT_ONE  = 1;
  localparam logic [CNTW-1:0]     WR_ONE   = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RELEASE
  } state_t;

  logic [0:WIDTH-1] imem [0:DEPTH-1];
  logic [0:WIDTH-1] dmem [0:DEPTH-1];

  state_t              state_q, state_d;
  logic [ADDRSIZE-1:0] addr_q, addr_d;
  logic [1:0]          idx_q, idx_d;
  logic [0:WIDTH-1]    buf_q, buf_d;
  logic [ADDRSIZE:0]   count_q, count_d;
  logic                err_q, err_d;
  logic [CNTW-1:0]     wr_cnt_q;

  logic                imem_we;
  logic [0:WIDTH-1]    imem_wdata;
  logic [0:WIDTH-1]    word_v;

  // Loader next-state, word assembly and status outputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    count_d    = count_q;
    err_d      = err_q;
    imem_we    = 1'b0;
    imem_wdata = '0;
    word_v     = buf_q;
    word_v[{idx_q, 3'b000} +: 8] = LD_BYTE;
    LD_READY   = 1'b0;
    CPU_HOLD   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (LD_START) begin
          state_d = S_LOAD;
          addr_d  = '0;
          idx_d   = '0;
          buf_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        LD_READY = 1'b1;
        CPU_HOLD = 1'b1;
        // A restart wins over a byte presented in the same cycle.
        if (LD_START) begin
          addr_d  = '0;
          idx_d   = '0;
          buf_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end else if (LD_VALID) begin
          if (idx_q == 2'd3 || LD_LAST) begin
            imem_we    = 1'b1;
            imem_wdata = word_v;
            addr_d     = addr_q + ADDR_ONE;
            count_d    = count_q + CNT_ONE;
            idx_d      = '0;
            buf_d      = '0;
            if (addr_q == '1) err_d = 1'b1;
            if (LD_LAST) begin
              if (idx_q != 2'd3) err_d = 1'b1;
              state_d = S_RELEASE;
            end
          end else begin
            buf_d = word_v;
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_RELEASE: begin
        CPU_HOLD = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Loader state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Saturating count of committed CPU stores.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q <= '0;
    end else if (MEM_CTRL && wr_cnt_q != '1) begin
      wr_cnt_q <= wr_cnt_q + WR_ONE;
    end
  end

  // Array writes; contents survive reset, but nothing is written while in it.
  always_ff @(posedge clk) begin
    if (!rst && MEM_CTRL) dmem[MEM_ADDR] <= MEM_WDATA;
    if (!rst && imem_we)  imem[addr_q]   <= imem_wdata;
  end

  // Combinational read ports; instruction port fetches NOPs while CPU is held.
  always_comb begin
    MEM_RDATA = dmem[MEM_ADDR];
    INS_MEM   = CPU_HOLD ? '0 : imem[INS_ADDR];
  end

  assign LD_COUNT = count_q;
  assign LD_ERR   = err_q;
  assign WR_COUNT = wr_cnt_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: stores, program loads, short final
// word, restart, reset behaviour and store counter saturation.
module tb_cpu_mem_responder;

  logic        clk;
  logic        rst;
  logic [11:0] MEM_ADDR;
  logic [0:31] MEM_WDATA;
  logic        MEM_CTRL;
  logic [0:31] MEM_RDATA;
  logic [11:0] INS_ADDR;
  logic [0:31] INS_MEM;
  logic        LD_START;
  logic        LD_VALID;
  logic [7:0]  LD_BYTE;
  logic        LD_LAST;
  logic        LD_READY;
  logic        CPU_HOLD;
  logic [12:0] LD_COUNT;
  logic        LD_ERR;
  logic [15:0] WR_COUNT;

  int unsigned passes = 0;
  int unsigned total  = 0;

  cpu_mem_responder #(.WIDTH(32), .ADDRSIZE(12), .CNTW(16)) dut (
    .clk(clk), .rst(rst),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_CTRL(MEM_CTRL),
    .MEM_RDATA(MEM_RDATA),
    .INS_ADDR(INS_ADDR), .INS_MEM(INS_MEM),
    .LD_START(LD_START), .LD_VALID(LD_VALID), .LD_BYTE(LD_BYTE),
    .LD_LAST(LD_LAST), .LD_READY(LD_READY), .CPU_HOLD(CPU_HOLD),
    .LD_COUNT(LD_COUNT), .LD_ERR(LD_ERR), .WR_COUNT(WR_COUNT)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    LD_VALID = 1'b1;
    LD_BYTE  = b;
    LD_LAST  = last;
    step();
    LD_VALID = 1'b0;
    LD_LAST  = 1'b0;
  endtask

  task automatic start_load();
    LD_START = 1'b1;
    step();
    LD_START = 1'b0;
  endtask

  task automatic ins_at(input logic [11:0] a, input logic [0:31] exp, input string tag);
    INS_ADDR = a;
    #1;
    chk(tag, INS_MEM, exp);
  endtask

  task automatic dat_at(input logic [11:0] a, input logic [0:31] exp, input string tag);
    MEM_ADDR = a;
    #1;
    chk(tag, MEM_RDATA, exp);
  endtask

  initial begin
    logic [7:0] prog1 [8];
    prog1 = '{8'h20, 8'h00, 8'h70, 8'h03, 8'h90, 8'h00, 8'h00, 8'h00};

    rst = 1'b1; MEM_ADDR = '0; MEM_WDATA = '0; MEM_CTRL = 1'b0;
    INS_ADDR = '0; LD_START = 1'b0; LD_VALID = 1'b0; LD_BYTE = '0; LD_LAST = 1'b0;
    #1;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_hold",   CPU_HOLD, 1'b0);
    chk("rst_ready",  LD_READY, 1'b0);
    chk("rst_count",  LD_COUNT, 13'd0);
    chk("rst_err",    LD_ERR,   1'b0);
    chk("rst_wrcnt",  WR_COUNT, 16'd0);

    // Data stores: addr 6 first as a known neighbour, then addr 5
    MEM_CTRL = 1'b1; MEM_ADDR = 12'd6; MEM_WDATA = 32'h12345678;
    step();
    chk("wrcnt_1", WR_COUNT, 16'd1);
    MEM_ADDR = 12'd5; MEM_WDATA = 32'h000000AB;
    step();
    MEM_CTRL = 1'b0;
    dat_at(12'd5, 32'h000000AB, "dmem5");
    dat_at(12'd6, 32'h12345678, "dmem6_unchanged");
    chk("wrcnt_2", WR_COUNT, 16'd2);

    // Full two-word load
    start_load();
    chk("ld1_ready", LD_READY, 1'b1);
    chk("ld1_hold",  CPU_HOLD, 1'b1);
    chk("ld1_cnt0",  LD_COUNT, 13'd0);
    for (int i = 0; i < 8; i++) begin
      ins_at(12'd0, 32'h0, "ld1_nop");
      send(prog1[i], i == 7);
    end
    chk("ld1_rel_hold",  CPU_HOLD, 1'b1);
    chk("ld1_rel_ready", LD_READY, 1'b0);
    ins_at(12'd0, 32'h0, "ld1_rel_nop");
    chk("ld1_count", LD_COUNT, 13'd2);
    chk("ld1_err",   LD_ERR,   1'b0);
    step();
    chk("ld1_hold_low", CPU_HOLD, 1'b0);
    ins_at(12'd0, 32'h20007003, "ld1_imem0");
    ins_at(12'd1, 32'h90000000, "ld1_imem1");

    // Short final word
    start_load();
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    chk("ld2_count", LD_COUNT, 13'd2);
    chk("ld2_err",   LD_ERR,   1'b1);
    step();
    ins_at(12'd0, 32'h11223344, "ld2_imem0");
    ins_at(12'd1, 32'hAABB0000, "ld2_imem1");

    // Restart after two bytes; restart beats a same-cycle byte
    start_load();
    chk("ld3_err_cleared", LD_ERR, 1'b0);
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    LD_START = 1'b1; LD_VALID = 1'b1; LD_BYTE = 8'h55;
    step();
    LD_START = 1'b0; LD_VALID = 1'b0;
    chk("ld3_restart_cnt", LD_COUNT, 13'd0);
    send(8'hC0, 1'b0); send(8'hDE, 1'b0); send(8'hCA, 1'b0); send(8'hFE, 1'b1);
    chk("ld3_count", LD_COUNT, 13'd1);
    chk("ld3_err",   LD_ERR,   1'b0);
    step();
    ins_at(12'd0, 32'hC0DECAFE, "ld3_imem0");
    ins_at(12'd1, 32'hAABB0000, "ld3_imem1_kept");

    // Store during reset is dropped, counter cleared
    rst = 1'b1; MEM_CTRL = 1'b1; MEM_ADDR = 12'd5; MEM_WDATA = 32'hDEADBEEF;
    step();
    rst = 1'b0; MEM_CTRL = 1'b0;
    dat_at(12'd5, 32'h000000AB, "rst_store_dropped");
    chk("rst_store_wrcnt", WR_COUNT, 16'd0);

    // Reset in the middle of a load
    start_load();
    send(8'h77, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_hold",  CPU_HOLD, 1'b0);
    chk("midrst_ready", LD_READY, 1'b0);
    chk("midrst_count", LD_COUNT, 13'd0);
    ins_at(12'd0, 32'hC0DECAFE, "midrst_imem0");

    // Store counter saturation
    MEM_CTRL = 1'b1; MEM_ADDR = 12'd7; MEM_WDATA = 32'h0000_0007;
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #1;
    chk("wrcnt_full", WR_COUNT, 16'hFFFF);
    step(); step(); step();
    MEM_CTRL = 1'b0;
    chk("wrcnt_sat", WR_COUNT, 16'hFFFF);
    dat_at(12'd7, 32'h00000007, "dmem7");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Memory-side responder for the 32-bit CPU's data and instruction ports. Holds separate instruction and data arrays (Harvard), answers the CPU's combinational instruction fetch and data read, commits CPU stores on the clock edge, and contains a byte-serial program loader that fills instruction memory while holding the CPU in reset. Sits directly between the CPU core and the board-level boot/debug link.

## Interface
- WIDTH, 32, data word width; bit 0 is MSB ([0:WIDTH-1] ordering)
- ADDRSIZE, 12, address width; each array holds 2^ADDRSIZE words
- CNTW, 16, width of store counter
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- MEM_ADDR  in  ADDRSIZE  data address from CPU
- MEM_WDATA  in  [0:WIDTH-1]  store data from CPU
- MEM_CTRL  in  1  0 = read, 1 = write
- MEM_RDATA  out  [0:WIDTH-1]  data read to CPU
- INS_ADDR  in  ADDRSIZE  instruction address (CPU pc)
- INS_MEM  out  [0:WIDTH-1]  instruction word to CPU
- LD_START  in  1  begin program load at instruction address 0
- LD_VALID  in  1  LD_BYTE valid
- LD_BYTE  in  8  load byte
- LD_LAST  in  1  qualifies final byte of program
- LD_READY  out  1  loader accepts a byte this cycle
- CPU_HOLD  out  1  drive to CPU rst; high while loading
- LD_COUNT  out  ADDRSIZE+1  words written by most recent load
- LD_ERR  out  1  sticky: short final word or address overflow
- WR_COUNT  out  CNTW  CPU stores committed, saturating

## Operation
- Data read: MEM_RDATA = dmem[MEM_ADDR], combinational; reflects a store one cycle after its commit edge.
- Data write: at rising edge with rst=0 and MEM_CTRL=1, dmem[MEM_ADDR] <= MEM_WDATA; WR_COUNT increments, holds at 2^CNTW-1. Writes honored in every loader state.
- Instruction read: INS_MEM = imem[INS_ADDR] combinational when CPU_HOLD=0; forced to 0 (NOP) when CPU_HOLD=1.
- Loader FSM states IDLE, LOAD, RELEASE.
  - IDLE: LD_READY=0, CPU_HOLD=0. LD_START=1 -> LOAD; load address, byte index, LD_COUNT cleared to 0, LD_ERR cleared.
  - LOAD: LD_READY=1, CPU_HOLD=1. Byte accepted when LD_VALID=1. Byte index k (0..3) places byte at word bits [8k:8k+7]; first byte lands in bits [0:7] (opcode byte). On fourth byte, or on any byte with LD_LAST=1, assembled word (unfilled bytes zero) written to imem[load address] at that edge; load address and LD_COUNT increment, index resets.
  - LD_LAST with k<3: word zero-padded and written, LD_ERR=1. LD_LAST -> RELEASE.
  - Load address wrapping 2^ADDRSIZE-1 -> 0: LD_ERR=1, load continues.
  - LD_START in LOAD: restart — address, index, LD_COUNT to 0, partial bytes discarded, no write; takes priority over a same-cycle byte.
  - RELEASE: one cycle, LD_READY=0, CPU_HOLD=1, then IDLE.
- Reset: FSM IDLE, LD_READY=0, CPU_HOLD=0, LD_COUNT=0, LD_ERR=0, WR_COUNT=0, index/address 0. Array contents are not modified by reset; a store with rst=1 is dropped. Reset mid-load abandons the partial word.

## Timing
- Read ports: zero-cycle latency, combinational from address.
- Store: commit at the edge MEM_CTRL=1 is sampled; visible on MEM_RDATA after that edge.
- LD_START sampled at edge N: LD_READY and CPU_HOLD high after N.
- Final byte accepted at edge M: imem word visible after M; RELEASE after M; CPU_HOLD falls after M+1.
- Load throughput: one byte per cycle, one word per four cycles.

## Test plan
- Store MEM_ADDR=5, MEM_WDATA=0x000000AB, MEM_CTRL=1 one cycle -> MEM_RDATA at addr 5 = 0x000000AB next cycle, WR_COUNT=1; addr 6 unchanged.
- Load bytes 20 00 70 03 90 00 00 00, LD_LAST on eighth -> imem[0]=0x20007003, imem[1]=0x90000000, LD_COUNT=2, LD_ERR=0, CPU_HOLD low two edges after last byte, INS_MEM=0 throughout hold.
- Load six bytes 11 22 33 44 AA BB, LD_LAST on sixth -> imem[1]=0xAABB0000, LD_COUNT=2, LD_ERR=1.
- LD_START after two bytes, then C0 DE CA FE + LD_LAST -> imem[0]=0xC0DECAFE, LD_COUNT=1, earlier bytes discarded.
- MEM_CTRL=1 with rst=1 -> no dmem change, WR_COUNT=0; force WR_COUNT to 0xFFFF via repeated stores -> stays 0xFFFF.
- Assert rst mid-load after one byte -> CPU_HOLD=0, LD_READY=0, imem[0] unchanged.
